// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 AXI read arbiter.
package tlk2711_pkg;
  localparam int         NUM_REQ        = 2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } arb_state_t;
endpackage

// File: rtl/tlk2711_axi_rd_arb_if.sv
// AXI read address/data channel bundle; master drives AR and rready, slave drives arready and R.
interface tlk2711_axi_rd_arb_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [3:0]            arid;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arvalid, araddr, arlen, arid, arsize, arburst, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  // Requesters only present address, length and rready to the arbiter.
  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/tlk2711_rr_sel.sv
// Two-input round-robin selector: prio names the requester that wins a tie.
module tlk2711_rr_sel
  import tlk2711_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               prio,
  output logic [NUM_REQ-1:0] gnt
);
  always_comb begin
    gnt = '0;
    if (req[prio])
      gnt[prio] = 1'b1;
    else if (req[~prio])
      gnt[~prio] = 1'b1;
  end
endmodule

// File: rtl/tlk2711_axi_rd_arb.sv
// Two-requester AXI read arbiter with a single burst outstanding on the shared HP port.
// Optional per-requester burst counters are enabled by defining TLK2711_ARB_STATS_EN.
//
// state   | meaning
// ST_IDLE | offer arready to the round-robin winner, capture its request
// ST_ADDR | present captured address to the slave until arready
// ST_DATA | route R beats to the granted requester until rlast
module tlk2711_axi_rd_arb
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128
) (
  input  logic clk,
  input  logic rst,
  tlk2711_axi_rd_arb_if.slave  s0,
  tlk2711_axi_rd_arb_if.slave  s1,
  tlk2711_axi_rd_arb_if.master m_axi,
  output logic o_rd_err,
  input  logic i_err_clr
`ifdef TLK2711_ARB_STATS_EN
  ,
  output logic [31:0] o_burst_cnt0,
  output logic [31:0] o_burst_cnt1
`endif
);
  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  gnt_idx;
  logic                  prio;
  logic                  arvalid_q;
  logic                  rd_err;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  in_idle;
  logic                  in_data;
  logic                  beat_ok;
  logic                  burst_done;

  assign req = {s1.arvalid, s0.arvalid};

  tlk2711_rr_sel u_rr_sel (
    .req  (req),
    .prio (prio),
    .gnt  (gnt)
  );

  assign in_idle    = (state == ST_IDLE);
  assign in_data    = (state == ST_DATA);
  assign beat_ok    = in_data & m_axi.rvalid & m_axi.rready;
  assign burst_done = beat_ok & m_axi.rlast;

  // arready is gated by rst so nothing is accepted while reset is held.
  assign s0.arready = in_idle & gnt[0] & ~rst;
  assign s1.arready = in_idle & gnt[1] & ~rst;

  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arid    = {3'b000, gnt_idx};
  assign m_axi.arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.rready  = in_data & (gnt_idx ? s1.rready : s0.rready);

  assign s0.rdata  = m_axi.rdata;
  assign s0.rresp  = m_axi.rresp;
  assign s0.rlast  = m_axi.rlast;
  assign s0.rvalid = in_data & ~gnt_idx & m_axi.rvalid;
  assign s1.rdata  = m_axi.rdata;
  assign s1.rresp  = m_axi.rresp;
  assign s1.rlast  = m_axi.rlast;
  assign s1.rvalid = in_data & gnt_idx & m_axi.rvalid;

  assign o_rd_err = rd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      gnt_idx   <= 1'b0;
      prio      <= 1'b0;
      arvalid_q <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            addr_q    <= gnt[1] ? s1.araddr : s0.araddr;
            len_q     <= gnt[1] ? s1.arlen  : s0.arlen;
            gnt_idx   <= gnt[1];
            prio      <= ~gnt[1];
            arvalid_q <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (burst_done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A new error beat wins over a clear in the same cycle.
      if (beat_ok && (m_axi.rresp != AXI_RESP_OKAY))
        rd_err <= 1'b1;
      else if (i_err_clr)
        rd_err <= 1'b0;
    end
  end

`ifdef TLK2711_ARB_STATS_EN
  logic [31:0] cnt0;
  logic [31:0] cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (i_err_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (burst_done) begin
      if (gnt_idx)
        cnt1 <= cnt1 + 32'd1;
      else
        cnt0 <= cnt0 + 32'd1;
    end
  end

  assign o_burst_cnt0 = cnt0;
  assign o_burst_cnt1 = cnt1;
`endif
endmodule

// File: tb/tb_tlk2711_axi_rd_arb.sv
// Scoreboard bench for tlk2711_axi_rd_arb: requester/slave models plus per-scenario checks.
module tb_tlk2711_axi_rd_arb;
  localparam int AW = 40;
  localparam int DW = 128;

  typedef struct packed { logic [3:0] id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_err_clr = 1'b0;
  logic o_rd_err;
`ifdef TLK2711_ARB_STATS_EN
  logic [31:0] o_burst_cnt0;
  logic [31:0] o_burst_cnt1;
`endif

  tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0 ();
  tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1 ();
  tlk2711_axi_rd_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

  assign s0.arid = '0;  assign s0.arsize = '0;  assign s0.arburst = '0;
  assign s1.arid = '0;  assign s1.arsize = '0;  assign s1.arburst = '0;

  tlk2711_axi_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s0        (s0),
    .s1        (s1),
    .m_axi     (m_axi),
    .o_rd_err  (o_rd_err),
    .i_err_clr (i_err_clr)
`ifdef TLK2711_ARB_STATS_EN
    ,
    .o_burst_cnt0 (o_burst_cnt0),
    .o_burst_cnt1 (o_burst_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  req_t  rq0[$], rq1[$];
  ar_t   exp_ar[$], obs_ar[$], slv_q[$];
  beat_t exp_b0[$], exp_b1[$], obs_b0[$], obs_b1[$];
  int    gnt_log[$];
  logic  obs_errf[$];

  int n_out = 0, ar_wait = 0, err_beat = -1, slv_beat = 0;
  int stall_cnt = 0, stab_err = 0, arr_viol = 0, mirror_err = 0, overlap_cnt = 0;
  int rv0_cnt = 0, rv1_cnt = 0, lat_err = 0, low_cnt = 0;
  bit rr_mode1 = 0, slv_flush = 0;

  function automatic beat_t mk_beat(ar_t a, int k);
    beat_t b;
    b.data = {8'h5A, a.addr, 80'(k)};
    b.resp = (k == err_beat) ? 2'b10 : 2'b00;
    b.last = (k == int'(a.len));
    return b;
  endfunction

  // Requester and slave models: sample at negedge, drive #1 after posedge.
  initial begin : bfm
    bit acc0, acc1, arhs, rhs, errp, lat_pend, prev_stall;
    ar_t cur_ar, prev_ar, a;
    req_t r;
    beat_t b;
    errp = 0; lat_pend = 0; prev_stall = 0; prev_ar = '0;
    s0.arvalid = 0; s0.araddr = '0; s0.arlen = '0; s0.rready = 1;
    s1.arvalid = 0; s1.araddr = '0; s1.arlen = '0; s1.rready = 1;
    m_axi.arready = 1; m_axi.rvalid = 0; m_axi.rdata = '0; m_axi.rresp = '0; m_axi.rlast = 0;
    forever begin
      @(negedge clk);
      acc0 = s0.arvalid & s0.arready;
      acc1 = s1.arvalid & s1.arready;
      if (acc0) gnt_log.push_back(0);
      if (acc1) gnt_log.push_back(1);
      if (lat_pend && m_axi.arvalid !== 1'b1) lat_err++;
      lat_pend = acc0 | acc1;
      cur_ar = '{m_axi.arid, m_axi.araddr, m_axi.arlen};
      arhs = m_axi.arvalid & m_axi.arready;
      if (arhs) obs_ar.push_back(cur_ar);
      if (prev_stall && (m_axi.arvalid !== 1'b1 || cur_ar !== prev_ar)) stab_err++;
      prev_stall = m_axi.arvalid & ~m_axi.arready;
      prev_ar = cur_ar;
      if (m_axi.arvalid & ~m_axi.arready) begin
        stall_cnt++;
        if (ar_wait > 0) ar_wait--;
      end
      if ((m_axi.arvalid || slv_q.size() > 0) && (s0.arready || s1.arready)) arr_viol++;
      if (slv_q.size() > 0 && m_axi.arvalid) overlap_cnt++;
      if (s0.rvalid) rv0_cnt++;
      if (s1.rvalid) rv1_cnt++;
      if (s1.rvalid && !s1.rready) low_cnt++;
      if ((s0.rvalid && m_axi.rready !== s0.rready) || (s1.rvalid && m_axi.rready !== s1.rready))
        mirror_err++;
      if (s0.rvalid & s0.rready) obs_b0.push_back('{s0.rdata, s0.rresp, s0.rlast});
      if (s1.rvalid & s1.rready) obs_b1.push_back('{s1.rdata, s1.rresp, s1.rlast});
      if (errp) obs_errf.push_back(o_rd_err);
      rhs  = m_axi.rvalid & m_axi.rready;
      errp = rhs && (m_axi.rresp != 2'b00);

      @(posedge clk);
      #1;
      if (acc0) begin
        r = rq0.pop_front();
        a = '{4'd0, r.addr, r.len};
        exp_ar.push_back(a);
        for (int k = 0; k <= int'(r.len); k++) exp_b0.push_back(mk_beat(a, k));
        n_out++;
      end
      if (acc1) begin
        r = rq1.pop_front();
        a = '{4'd1, r.addr, r.len};
        exp_ar.push_back(a);
        for (int k = 0; k <= int'(r.len); k++) exp_b1.push_back(mk_beat(a, k));
        n_out++;
      end
      if (arhs) slv_q.push_back(cur_ar);
      if (rhs && slv_q.size() > 0) begin
        if (slv_beat == int'(slv_q[0].len)) begin
          void'(slv_q.pop_front());
          slv_beat = 0;
          n_out--;
        end else begin
          slv_beat++;
        end
      end
      if (slv_flush) begin
        slv_q.delete(); slv_beat = 0; n_out = 0; slv_flush = 0;
      end
      m_axi.arready = (ar_wait == 0);
      if (slv_q.size() > 0) begin
        b = mk_beat(slv_q[0], slv_beat);
        m_axi.rvalid = 1; m_axi.rdata = b.data; m_axi.rresp = b.resp; m_axi.rlast = b.last;
      end else begin
        m_axi.rvalid = 0; m_axi.rlast = 0; m_axi.rresp = '0;
      end
      s0.arvalid = (rq0.size() > 0);
      if (rq0.size() > 0) begin s0.araddr = rq0[0].addr; s0.arlen = rq0[0].len; end
      s1.arvalid = (rq1.size() > 0);
      if (rq1.size() > 0) begin s1.araddr = rq1[0].addr; s1.arlen = rq1[0].len; end
      s1.rready = rr_mode1 ? ~s1.rready : 1'b1;
    end
  end

  task automatic wait_done(input string nm);
    int t = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || n_out != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    if (t >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout got busy after %0d cycles want idle", nm, t);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m_axi.arvalid, m_axi.rready, s0.arready, s1.arready, s0.rvalid, s1.rvalid, o_rd_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0000000", {m_axi.arvalid, m_axi.rready, s0.arready,
               s1.arready, s0.rvalid, s1.rvalid, o_rd_err});
    end
    n_cmp++;
    if (m_axi.araddr !== 40'h0 || m_axi.arlen !== 8'd0 || m_axi.arid !== 4'd0) begin
      n_err++;
      $display("FAIL reset_ar got %h/%0d/%0d want 0/0/0", m_axi.araddr, m_axi.arlen, m_axi.arid);
    end
`ifdef TLK2711_ARB_STATS_EN
    n_cmp++;
    if (o_burst_cnt0 !== 32'd0 || o_burst_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", o_burst_cnt0, o_burst_cnt1);
    end
`endif
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    n_cmp++;
    if (m_axi.arsize !== 3'd4 || m_axi.arburst !== 2'b01) begin
      n_err++;
      $display("FAIL const_ar got size %0d burst %0d want 4/1", m_axi.arsize, m_axi.arburst);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    ar_t oa, ea;
    beat_t ob, eb;
    gnt_log.delete(); overlap_cnt = 0; lat_err = 0;
    @(posedge clk); #3;
    rq0.push_back('{40'h00_0000_0100, 8'd3});
    rq0.push_back('{40'h00_0000_0300, 8'd1});
    rq1.push_back('{40'h00_0000_0200, 8'd2});
    rq1.push_back('{40'h00_0000_0400, 8'd0});
    wait_done("rr");
    n_cmp++;
    if (gnt_log.size() != 4) begin
      n_err++;
      $display("FAIL rr_count got %0d grants want 4", gnt_log.size());
    end
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      n_cmp++;
      if (gnt_log[i] !== exp_g[i]) begin
        n_err++;
        $display("FAIL rr_grant%0d got %0d want %0d", i, gnt_log[i], exp_g[i]);
      end
    end
    n_cmp++;
    if (overlap_cnt !== 0 || lat_err !== 0) begin
      n_err++;
      $display("FAIL rr_overlap got overlap %0d latency_err %0d want 0/0", overlap_cnt, lat_err);
    end
    while (obs_ar.size() > 0 && exp_ar.size() > 0) begin
      oa = obs_ar.pop_front(); ea = exp_ar.pop_front();
      n_cmp++;
      if (oa !== ea) begin
        n_err++;
        $display("FAIL rr_ar got %h want %h", oa, ea);
      end
    end
    while (obs_b0.size() > 0 && exp_b0.size() > 0) begin
      ob = obs_b0.pop_front(); eb = exp_b0.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL rr_beat0 got %h want %h", ob, eb);
      end
    end
    while (obs_b1.size() > 0 && exp_b1.size() > 0) begin
      ob = obs_b1.pop_front(); eb = exp_b1.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL rr_beat1 got %h want %h", ob, eb);
      end
    end
    n_cmp++;
    if (obs_ar.size() + exp_ar.size() + obs_b0.size() + exp_b0.size() + obs_b1.size() + exp_b1.size() != 0) begin
      n_err++;
      $display("FAIL rr_leftover got %0d/%0d/%0d/%0d/%0d/%0d want all 0", obs_ar.size(), exp_ar.size(),
               obs_b0.size(), exp_b0.size(), obs_b1.size(), exp_b1.size());
    end
  endtask

  task automatic test_single_burst();
    ar_t oa;
    beat_t ob, eb;
    int nb = 0;
    lat_err = 0;
    @(posedge clk); #3;
    rq0.push_back('{40'h00_0000_0000, 8'd15});
    wait_done("single");
    n_cmp++;
    if (obs_ar.size() != 1) begin
      n_err++;
      $display("FAIL single_ar_count got %0d want 1", obs_ar.size());
    end else begin
      oa = obs_ar.pop_front();
      n_cmp++;
      if (oa !== ar_t'{4'd0, 40'h0, 8'd15}) begin
        n_err++;
        $display("FAIL single_ar got id %0d addr %h len %0d want 0/0/15", oa.id, oa.addr, oa.len);
      end
    end
    exp_ar.delete();
    n_cmp++;
    if (lat_err !== 0) begin
      n_err++;
      $display("FAIL single_latency got %0d late arvalid want 0", lat_err);
    end
    while (obs_b0.size() > 0 && exp_b0.size() > 0) begin
      ob = obs_b0.pop_front(); eb = exp_b0.pop_front();
      nb++;
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL single_beat%0d got %h/%0d/%0d want %h/%0d/%0d", nb, ob.data, ob.resp, ob.last,
                 eb.data, eb.resp, eb.last);
      end
    end
    n_cmp++;
    if (nb !== 16 || obs_b0.size() != 0 || exp_b0.size() != 0 || obs_b1.size() != 0) begin
      n_err++;
      $display("FAIL single_count got %0d beats (s1 %0d) want 16 (s1 0)", nb + obs_b0.size(), obs_b1.size());
    end
    n_cmp++;
    if (m_axi.arvalid !== 1'b0 || m_axi.rready !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle got arvalid %b rready %b want 0/0", m_axi.arvalid, m_axi.rready);
    end
  endtask

  task automatic test_arready_stall();
    ar_t oa, ea;
    beat_t ob, eb;
    stall_cnt = 0; stab_err = 0; arr_viol = 0;
    ar_wait = 20;
    @(posedge clk); #3;
    rq0.push_back('{40'h00_0055_0000, 8'd1});
    rq1.push_back('{40'h00_0066_0000, 8'd0});
    wait_done("stall");
    n_cmp++;
    if (stall_cnt !== 20) begin
      n_err++;
      $display("FAIL stall_cycles got %0d want 20", stall_cnt);
    end
    n_cmp++;
    if (stab_err !== 0 || arr_viol !== 0) begin
      n_err++;
      $display("FAIL stall_stable got unstable %0d arready_violations %0d want 0/0", stab_err, arr_viol);
    end
    while (obs_ar.size() > 0 && exp_ar.size() > 0) begin
      oa = obs_ar.pop_front(); ea = exp_ar.pop_front();
      n_cmp++;
      if (oa !== ea) begin
        n_err++;
        $display("FAIL stall_ar got %h want %h", oa, ea);
      end
    end
    while (obs_b0.size() > 0 && exp_b0.size() > 0) begin
      ob = obs_b0.pop_front(); eb = exp_b0.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL stall_beat0 got %h want %h", ob, eb);
      end
    end
    while (obs_b1.size() > 0 && exp_b1.size() > 0) begin
      ob = obs_b1.pop_front(); eb = exp_b1.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL stall_beat1 got %h want %h", ob, eb);
      end
    end
    n_cmp++;
    if (obs_ar.size() + exp_ar.size() + obs_b0.size() + exp_b0.size() + obs_b1.size() + exp_b1.size() != 0) begin
      n_err++;
      $display("FAIL stall_leftover got %0d entries want 0", obs_ar.size() + exp_ar.size() + obs_b0.size() +
               exp_b0.size() + obs_b1.size() + exp_b1.size());
    end
  endtask

  task automatic test_rready_toggle();
    beat_t ob, eb;
    int nb = 0, base0;
    base0 = rv0_cnt; mirror_err = 0; low_cnt = 0;
    @(posedge clk); #3;
    rr_mode1 = 1;
    rq1.push_back('{40'h00_0000_ABC0, 8'd7});
    wait_done("toggle");
    rr_mode1 = 0;
    exp_ar.delete(); obs_ar.delete();
    while (obs_b1.size() > 0 && exp_b1.size() > 0) begin
      ob = obs_b1.pop_front(); eb = exp_b1.pop_front();
      nb++;
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL toggle_beat%0d got %h want %h", nb, ob, eb);
      end
    end
    n_cmp++;
    if (nb !== 8 || obs_b1.size() != 0 || exp_b1.size() != 0) begin
      n_err++;
      $display("FAIL toggle_count got %0d beats want 8", nb + obs_b1.size());
    end
    n_cmp++;
    if (mirror_err !== 0 || low_cnt == 0) begin
      n_err++;
      $display("FAIL toggle_mirror got mismatches %0d stalled_beats %0d want 0/>0", mirror_err, low_cnt);
    end
    n_cmp++;
    if (rv0_cnt - base0 !== 0 || obs_b0.size() != 0) begin
      n_err++;
      $display("FAIL toggle_s0_quiet got %0d s0 rvalid cycles want 0", rv0_cnt - base0);
    end
  endtask

  task automatic test_rd_err();
    beat_t ob, eb;
    @(posedge clk); #2; i_err_clr = 1;
    @(posedge clk); #2; i_err_clr = 0;
    obs_errf.delete();
    err_beat = 2;
    rq0.push_back('{40'h00_0000_7000, 8'd3});
    wait_done("err");
    while (obs_b0.size() > 0 && exp_b0.size() > 0) begin
      ob = obs_b0.pop_front(); eb = exp_b0.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL err_beat got resp %0d data %h want resp %0d data %h", ob.resp, ob.data, eb.resp, eb.data);
      end
    end
    exp_ar.delete(); obs_ar.delete();
    n_cmp++;
    if (obs_errf.size() != 1 || obs_errf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL err_next_cycle got %0d samples first %b want 1 sample of 1", obs_errf.size(),
               obs_errf.size() > 0 ? obs_errf[0] : 1'bx);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (o_rd_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky got %b want 1", o_rd_err);
    end
`ifdef TLK2711_ARB_STATS_EN
    n_cmp++;
    if (o_burst_cnt0 !== 32'd1 || o_burst_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL stats_count got %0d/%0d want 1/0", o_burst_cnt0, o_burst_cnt1);
    end
`endif
    @(posedge clk); #2; i_err_clr = 1;
    @(posedge clk); #2; i_err_clr = 0;
    @(negedge clk);
    n_cmp++;
    if (o_rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear got %b want 0", o_rd_err);
    end
`ifdef TLK2711_ARB_STATS_EN
    n_cmp++;
    if (o_burst_cnt0 !== 32'd0 || o_burst_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL stats_clear got %0d/%0d want 0/0", o_burst_cnt0, o_burst_cnt1);
    end
`endif
    // Clear held through an error beat: the error still sets the flag that cycle.
    obs_errf.delete();
    i_err_clr = 1;
    rq0.push_back('{40'h00_0000_7100, 8'd3});
    wait_done("err_clr");
    i_err_clr = 0;
    n_cmp++;
    if (obs_errf.size() != 1 || obs_errf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL err_set_wins got %0d samples first %b want 1 sample of 1", obs_errf.size(),
               obs_errf.size() > 0 ? obs_errf[0] : 1'bx);
    end
    @(negedge clk);
    n_cmp++;
    if (o_rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr_after got %b want 0", o_rd_err);
    end
    err_beat = -1;
    exp_ar.delete(); obs_ar.delete(); exp_b0.delete(); obs_b0.delete();
  endtask

  task automatic test_reset_mid_burst();
    beat_t ob, eb;
    ar_t oa;
    int t = 0, base0, base1;
    err_beat = 1;
    @(posedge clk); #3;
    rq0.push_back('{40'h00_0000_2000, 8'd15});
    while (obs_b0.size() < 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (obs_b0.size() < 4 || o_rd_err !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup got %0d beats err %b want 4/1", obs_b0.size(), o_rd_err);
    end
    @(posedge clk); #3;
    rst = 1;
    #1;
    n_cmp++;
    if ({m_axi.arvalid, m_axi.rready, s0.rvalid, s1.rvalid, s0.arready, s1.arready, o_rd_err} !== 7'b0) begin
      n_err++;
      $display("FAIL midrst_outputs got %b want 0000000", {m_axi.arvalid, m_axi.rready, s0.rvalid,
               s1.rvalid, s0.arready, s1.arready, o_rd_err});
    end
    n_cmp++;
    if (m_axi.araddr !== 40'h0 || m_axi.arlen !== 8'd0) begin
      n_err++;
      $display("FAIL midrst_ar got %h/%0d want 0/0", m_axi.araddr, m_axi.arlen);
    end
    base0 = rv0_cnt; base1 = rv1_cnt;
    @(posedge clk); #2; rst = 0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rv0_cnt - base0 !== 0 || rv1_cnt - base1 !== 0 || m_axi.rready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_no_fwd got s0 %0d s1 %0d rready %b want 0/0/0", rv0_cnt - base0,
               rv1_cnt - base1, m_axi.rready);
    end
    slv_flush = 1;
    @(posedge clk); #3;
    err_beat = -1;
    exp_ar.delete(); obs_ar.delete(); exp_b0.delete(); obs_b0.delete();
    rq1.push_back('{40'h12_3456_7890, 8'd3});
    wait_done("midrst");
    n_cmp++;
    if (obs_ar.size() != 1) begin
      n_err++;
      $display("FAIL midrst_ar_count got %0d want 1", obs_ar.size());
    end else begin
      oa = obs_ar.pop_front();
      n_cmp++;
      if (oa !== ar_t'{4'd1, 40'h12_3456_7890, 8'd3}) begin
        n_err++;
        $display("FAIL midrst_regrant got %h want id 1 addr 1234567890 len 3", oa);
      end
    end
    while (obs_b1.size() > 0 && exp_b1.size() > 0) begin
      ob = obs_b1.pop_front(); eb = exp_b1.pop_front();
      n_cmp++;
      if (ob !== eb) begin
        n_err++;
        $display("FAIL midrst_beat got %h want %h", ob, eb);
      end
    end
    n_cmp++;
    if (obs_b1.size() != 0 || exp_b1.size() != 0 || obs_b0.size() != 0) begin
      n_err++;
      $display("FAIL midrst_leftover got %0d/%0d/%0d want 0/0/0", obs_b1.size(), exp_b1.size(), obs_b0.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_arready_stall();
    test_rready_toggle();
    test_rd_err();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500us");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tlk2711_axi_rd_arb.md
TLK2711_AXI_RD_ARB -- requirements
Module: tlk2711_axi_rd_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 40, AXI read address width.
REQ-002 Parameter DATA_WIDTH, default 128, AXI read data width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sN_arvalid / sN_araddr / sN_arlen  input  1 / ADDR_WIDTH / 8  requester N (N=0,1) burst request.
REQ-006 sN_arready  output  1  request N accepted this cycle.
REQ-007 sN_rdata / sN_rresp / sN_rlast / sN_rvalid  output  DATA_WIDTH / 2 / 1 / 1  read data routed to requester N.
REQ-008 sN_rready  input  1  requester N can accept data.
REQ-009 m_axi_arvalid / m_axi_araddr / m_axi_arlen  output  1 / ADDR_WIDTH / 8  shared HP master address channel.
REQ-010 m_axi_arid / m_axi_arsize / m_axi_arburst  output  4 / 3 / 2  constant: arid = granted index; arsize = log2(DATA_WIDTH/8); arburst = INCR.
REQ-011 m_axi_arready  input  1  slave address accept.
REQ-012 m_axi_rdata / m_axi_rresp / m_axi_rlast / m_axi_rvalid  input  DATA_WIDTH / 2 / 1 / 1  slave read data.
REQ-013 m_axi_rready  output  1  master data accept.
REQ-014 o_rd_err  output  1  sticky flag: any beat with rresp != OKAY.
REQ-015 i_err_clr  input  1  single-cycle pulse that clears o_rd_err.

Function
REQ-016 FSM states: IDLE, ADDR, DATA; exactly one burst outstanding on the master port at any time.
REQ-017 IDLE: sN_arready = 1 combinationally for the selected requester only, if its sN_arvalid = 1; on that edge araddr/arlen/index are registered and the FSM goes to ADDR.
REQ-018 Selection: round-robin; when both valid, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 ADDR: m_axi_arvalid = 1 with registered address/len (latency: 1 cycle from sN_arvalid&sN_arready to m_axi_arvalid); held stable until m_axi_arready; on handshake -> DATA.
REQ-020 DATA: m_axi_rready = sG_rready; sG_rvalid = m_axi_rvalid; rdata/rresp/rlast pass through combinationally to the granted requester G; the other requester sees rvalid = 0.
REQ-021 DATA exits to IDLE on m_axi_rvalid & m_axi_rready & m_axi_rlast; a new grant can occur in the IDLE cycle that follows.
REQ-022 Outside DATA: m_axi_rready = 0 and both sN_rvalid = 0; beats arriving in IDLE or ADDR are not accepted.
REQ-023 arlen = 0 (single beat) is legal; rlast on the first beat ends the burst.
REQ-024 o_rd_err sets on any accepted beat with rresp != 2'b00; i_err_clr in the same cycle as a new error leaves the flag set.
REQ-025 sN_arready is never asserted outside IDLE; requests held during ADDR/DATA wait without loss.

Reset
REQ-026 Asynchronous rst forces: IDLE, m_axi_arvalid = 0, m_axi_rready = 0, all sN_arready/sN_rvalid = 0, o_rd_err = 0, round-robin pointer to requester 0, registered addr/len = 0.
REQ-027 Reset mid-burst abandons the burst; no remaining beats are forwarded after release.

Configuration
REQ-028 Macro TLK2711_ARB_STATS_EN: when defined, adds outputs o_burst_cnt0, o_burst_cnt1 (32-bit each, wrap-around), incremented on each completed burst per requester, reset to 0 and cleared by i_err_clr; when undefined, these ports and counters do not exist and all other behaviour is identical.

Structure
REQ-029 Shared package tlk2711_pkg holds the FSM state enum, AXI_RESP_OKAY, AXI_BURST_INCR and the requester-count constant (2).
REQ-030 Sub-module tlk2711_rr_sel: 2-input round-robin selector (request vector, last-grant pointer -> one-hot grant); no other sub-modules.

Verification
REQ-031 s0 requests addr 0x000000 len 15, slave arready = 1 -> m_axi_arvalid one cycle after accept, araddr 0x000000, arlen 15, arid 0; 16 beats reach s0 only; s0_rlast on beat 16; FSM back in IDLE.
REQ-032 s0 and s1 request in the same cycle, both repeatedly -> grants alternate 0,1,0,1; the second request waits until the first rlast.
REQ-033 m_axi_arready held low 20 cycles -> m_axi_arvalid/araddr stable for all 20; no sN_arready during them.
REQ-034 s1 rready toggles every cycle during a len 7 burst -> m_axi_rready mirrors it; exactly 8 beats transferred; no beats reach s0.
REQ-035 beat 3 of a burst returns rresp = 2'b10 -> o_rd_err = 1 the next cycle and stays set until i_err_clr; with TLK2711_ARB_STATS_EN the counts read 1/0 after one s0 burst.
REQ-036 rst asserted during beat 5 of a len 15 burst -> all outputs at reset values immediately; the next s1 request after release is granted normally.
